vc_writeback_queue: RTL
=======================

Name: vc_writeback_queue

Overview:
- Transmit side of the victim-cache eviction path. It accepts lines displaced from the L1.5 victim cache and keeps only the dirty (M-state) ones.
- Dirty lines are buffered in order and sent to the L2-bound writeback channel as multi-beat messages over a valid/ready handshake.
- A registered snoop port reports whether an address is still pending writeback, so a refill is not sourced from stale L2 data.

Parameters:
- ADDR_WIDTH, 36, line address width (tag 29 + index 7).
- LINE_WIDTH, 128, cache line width in bits.
- BEAT_WIDTH, 64, writeback channel data width. LINE_WIDTH must be an integer multiple of it; NUM_BEATS = LINE_WIDTH/BEAT_WIDTH.
- DEPTH, 4, queue entries. Must be a power of 2 and at least 2.
- MESI_WIDTH, 2, MESI state width.
- MESI_M, 2'b11, encoding of the Modified state.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- enq_val_i  in  1  victim displaced this cycle
- enq_addr_i  in  ADDR_WIDTH  displaced line address
- enq_data_i  in  LINE_WIDTH  displaced line data
- enq_mesi_i  in  MESI_WIDTH  displaced line state
- full_o  out  1  queue holds DEPTH entries
- overflow_o  out  1  sticky: a dirty enqueue was dropped
- wb_val_o  out  1  writeback beat valid
- wb_ready_i  in  1  channel accepts beat
- wb_addr_o  out  ADDR_WIDTH  head entry address, held for all beats
- wb_data_o  out  BEAT_WIDTH  current beat, low slice first
- wb_last_o  out  1  current beat is beat NUM_BEATS-1
- check_val_i  in  1  snoop request
- check_addr_i  in  ADDR_WIDTH  snoop address
- pending_hit_o  out  1  registered snoop result

Behaviour:
- Reset (clk edge with rst_n=0):
  - head/tail pointers, count, beat counter and FSM are cleared (FSM to IDLE).
  - wb_val_o=0, wb_last_o=0, full_o=0, overflow_o=0, pending_hit_o=0.
  - Reset mid-message discards all entries and the partial message; no further beats of it are sent.
- Enqueue (accepted) requires enq_val_i=1, enq_mesi_i==MESI_M, and count<DEPTH, all evaluated on the current registered count.
  - The entry is written at tail, tail increments (wraps mod DEPTH), count increments.
  - Non-M enq_val_i (I/S/E) has no effect: clean victims are silently dropped.
- Enqueue while full: the line is dropped and overflow_o is set to 1. It stays 1 until reset.
  - A pop in the same cycle does not free space for that enqueue; there is no bypass.
- Duplicate addresses may be enqueued. They are sent in enqueue order, each as a full message.
- FSM states: IDLE and SEND.
  - IDLE to SEND when count>0 (registered). An enqueue into an empty queue at edge N gives wb_val_o=1 after edge N+1, i.e. 1-cycle latency.
  - SEND: wb_val_o=1. wb_addr_o/wb_data_o/wb_last_o come from the head entry and beat counter, and stay stable until the handshake.
  - Handshake is wb_val_o & wb_ready_i. On a non-last beat, beat increments.
  - On the last beat, beat returns to 0, head increments (wraps), count decrements, and the FSM goes to IDLE if the new count is 0, else stays in SEND for the next entry with no bubble.
- wb_val_o is never combinationally dependent on wb_ready_i. wb_ready_i may toggle freely; a low wb_ready_i stalls with outputs held.
- Simultaneous enqueue and last-beat pop: count is unchanged and both pointers advance.
- Beat n data = line bits [n*BEAT_WIDTH +: BEAT_WIDTH].
- full_o = (count==DEPTH), registered-state derived.
- Snoop:
  - pending_hit_o at edge N+1 = check_val_i and check_addr_i matches an entry valid at cycle N, or the entry accepted at cycle N.
  - Entries whose last beat completes at cycle N are excluded.
  - If check_val_i=0, pending_hit_o=0 next cycle.
- Count width covers 0..DEPTH inclusive. Pointer width is log2(DEPTH).

Test Plan:
- After reset, enq addr=0x123, data=0xAAAA..(hi)/0x5555..(lo), mesi=M, with wb_ready_i=1 -> wb_val_o rises one cycle later.
  - Beat0 data=0x5555.., last=0; beat1 data=0xAAAA.., last=1; addr=0x123 both beats; then wb_val_o=0.
- Enqueue with mesi=E and mesi=S -> wb_val_o stays 0, full_o stays 0, count stays 0.
- Hold wb_ready_i=0 and enqueue 5 M lines -> full_o=1 after the 4th, overflow_o=1 after the 5th.
  - Release ready -> exactly 4 messages (8 beats) in enqueue order, back-to-back.
- Enqueue 3 M lines and toggle wb_ready_i every cycle -> every beat is transferred exactly once with stable outputs during stalls.
  - Pointers wrap correctly when a 4th/5th line is enqueued after drain.
- Snoop addr=0x123 while it is queued -> pending_hit_o=1 next cycle.
  - Snoop in the same cycle as its last-beat handshake -> 0.
  - Snoop in the same cycle as its enqueue into an empty queue -> 1.
- Assert rst_n=0 after beat0 of a 2-entry queue -> next cycle wb_val_o=0, full_o=0, overflow_o=0, pending_hit_o=0, and no beat1 appears.

Source files
------------

// File: rtl/vc_writeback_queue.sv
// Victim-cache writeback queue: keeps dirty (M) victims in FIFO order and streams each
// line to the L2 writeback channel as NUM_BEATS beats; a registered snoop flags pending lines.
module vc_writeback_queue #(
  parameter int ADDR_WIDTH = 36,
  parameter int LINE_WIDTH = 128,
  parameter int BEAT_WIDTH = 64,
  parameter int DEPTH      = 4,
  parameter int MESI_WIDTH = 2,
  parameter logic [MESI_WIDTH-1:0] MESI_M = 2'b11
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enq_val_i,
  input  logic [ADDR_WIDTH-1:0] enq_addr_i,
  input  logic [LINE_WIDTH-1:0] enq_data_i,
  input  logic [MESI_WIDTH-1:0] enq_mesi_i,
  output logic                  full_o,
  output logic                  overflow_o,
  output logic                  wb_val_o,
  input  logic                  wb_ready_i,
  output logic [ADDR_WIDTH-1:0] wb_addr_o,
  output logic [BEAT_WIDTH-1:0] wb_data_o,
  output logic                  wb_last_o,
  input  logic                  check_val_i,
  input  logic [ADDR_WIDTH-1:0] check_addr_i,
  output logic                  pending_hit_o
);
  localparam int NUM_BEATS = LINE_WIDTH / BEAT_WIDTH;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int BW = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [BW-1:0] LAST_BEAT = BW'(NUM_BEATS - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                                 state;
  logic [ADDR_WIDTH-1:0]                  mem_addr [DEPTH];
  logic [NUM_BEATS-1:0][BEAT_WIDTH-1:0]   mem_data [DEPTH];
  logic [PW-1:0]                          head, tail, off;
  logic [CW-1:0]                          count, count_nxt;
  logic [BW-1:0]                          beat;
  logic                                   is_dirty, enq_acc, fire, pop, hit_q, hit_enq;

  assign full_o    = (count == FULL_CNT);
  assign is_dirty  = enq_val_i && (enq_mesi_i == MESI_M);
  // No bypass: space freed by a same-cycle pop is not visible to the enqueue.
  assign enq_acc   = is_dirty && !full_o;
  assign wb_val_o  = (state == SEND);
  assign wb_last_o = wb_val_o && (beat == LAST_BEAT);
  assign wb_addr_o = mem_addr[head];
  assign wb_data_o = mem_data[head][beat];
  assign fire      = wb_val_o && wb_ready_i;
  assign pop       = fire && wb_last_o;
  assign count_nxt = count + CW'(enq_acc) - CW'(pop);
  assign hit_enq   = enq_acc && (enq_addr_i == check_addr_i);

  // Live entries are those within count of head; the entry retiring this cycle is excluded.
  always_comb begin
    hit_q = 1'b0;
    off   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = PW'(i) - head;
      if ((CW'(off) < count) && !(pop && (PW'(i) == head)) && (mem_addr[i] == check_addr_i))
        hit_q = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (enq_acc) begin
      mem_addr[tail] <= enq_addr_i;
      mem_data[tail] <= enq_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      head          <= '0;
      tail          <= '0;
      count         <= '0;
      beat          <= '0;
      overflow_o    <= 1'b0;
      pending_hit_o <= 1'b0;
    end else begin
      if (enq_acc) tail <= tail + PW'(1);
      if (pop)     head <= head + PW'(1);
      count <= count_nxt;
      if (is_dirty && full_o) overflow_o <= 1'b1;
      pending_hit_o <= check_val_i && (hit_q || hit_enq);
      case (state)
        IDLE: begin
          beat <= '0;
          if (count != '0) state <= SEND;
        end
        SEND: begin
          if (fire) begin
            if (wb_last_o) begin
              beat <= '0;
              if (count_nxt == '0) state <= IDLE;
            end else begin
              beat <= beat + BW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
